// File: rtl/lsu_bus_master.sv
// Load/store bus initiator for the MEM stage of a multi-cycle core.
// Takes one load or store at a time and rejects illegal func3 codes and
// misaligned addresses without touching the bus. Legal requests become one
// word-aligned bus transfer, with byte enables and lane-replicated store data.
// The transfer is abandoned if bus_ready does not arrive within TIMEOUT cycles.
// Each request ends with a single-cycle response pulse carrying the extracted
// load data or an error code.
//
// Handshakes:
//   core side: a request is taken on any rising edge where req_valid && req_ready.
//              req_ready is high only in IDLE. The core holds req_valid and the
//              request fields until that edge. rsp_valid is a one-cycle pulse
//              with no back-pressure.
//   bus side:  bus_req and every bus_* field stay stable from the edge that
//              raises bus_req until the edge that completes the transfer. The
//              transfer completes on any edge where bus_req && bus_ready.
//              bus_ready is ignored whenever no transfer is outstanding.
module lsu_bus_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_func3,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ready,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        lo_q, lo_d;
  logic [2:0]        f3_q, f3_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_err_q, rsp_err_d;

  logic              req_illegal;
  logic              req_misaligned;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;

  // Extract the addressed byte/half/word from a bus word and extend it.
  // func3[2] selects zero extension (LBU/LHU). Only legal load codes reach here.
  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  lo,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Request legality: loads allow 000/001/010/100/101; stores allow 000/001/010.
  always_comb begin
    if (req_we) begin
      req_illegal = req_func3[2] | (req_func3[1:0] == 2'b11);
    end else begin
      req_illegal = (req_func3[1:0] == 2'b11) | (req_func3 == 3'b110);
    end
    req_misaligned = ((req_func3[1:0] == 2'b01) & req_addr[0]) |
                     ((req_func3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
  end

  // Byte enables and replicated write data for the incoming request.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = req_wdata;
    if (req_we) begin
      case (req_func3[1:0])
        2'b00: begin
          lane_be    = 4'b0001 << req_addr[1:0];
          lane_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          lane_be    = req_addr[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          lane_be    = 4'b1111;
          lane_wdata = req_wdata;
        end
      endcase
    end
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    lo_d        = lo_q;
    f3_d        = f3_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d = req_we;
          lo_d = req_addr[1:0];
          f3_d = req_func3;
          if (req_illegal) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = ERR_ILLEGAL;
          end else if (req_misaligned) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = ERR_MISALIGN;
          end else begin
            state_d     = ST_BUS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            bus_be_d    = lane_be;
            bus_wdata_d = lane_wdata;
          end
        end
      end

      ST_BUS: begin
        if (bus_ready) begin
          state_d     = ST_RESP;
          cnt_d       = '0;
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : extract(f3_q, lo_q, bus_rdata);
          rsp_err_d   = ERR_OK;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          cnt_d       = '0;
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = ERR_OK;
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      lo_q        <= 2'b00;
      f3_q        <= 3'b000;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      lo_q        <= lo_d;
      f3_q        <= f3_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed steps from the test plan followed by
// randomized loads/stores checked against a byte-array memory model.
module tb_lsu_bus_master;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [1:0]  dbg_state_o;

  int checks   = 0;
  int failures = 0;

  // Memory seen by the bus responder, and the model's view of the same memory.
  logic [7:0] slv_mem [0:63];
  logic [7:0] ref_mem [0:63];

  // Responder controls.
  int wait_cfg   = 0;
  bit hold_low   = 0;
  bit force_ready = 0;

  // Results captured by run_req.
  int          r_lat;
  int          r_bus_cycles;
  bit          r_unstable;
  bit          r_overlap;
  logic [31:0] r_rdata;
  logic [1:0]  r_err;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_after_valid;
  logic        r_after_ready;

  lsu_bus_master #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_func3  (req_func3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ready  (bus_ready),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Bus responder: raises bus_ready after wait_cfg wait cycles, applies writes by byte enable.
  initial begin
    int wcnt;
    int base;
    wcnt = 0;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus_req) begin
        wcnt = 0;
        bus_ready = force_ready;
        bus_rdata = $urandom;
      end else begin
        if (!hold_low && wcnt == wait_cfg) begin
          base = int'({bus_addr[5:2], 2'b00});
          bus_ready = 1'b1;
          bus_rdata = {slv_mem[base+3], slv_mem[base+2], slv_mem[base+1], slv_mem[base]};
          if (bus_we) begin
            for (int b = 0; b < 4; b++) begin
              if (bus_be[b]) slv_mem[base+b] = bus_wdata[8*b +: 8];
            end
          end
        end else begin
          bus_ready = force_ready;
          bus_rdata = $urandom;
        end
        wcnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference model: legality, alignment and memory effects straight from the ISA rules.
  function automatic bit ref_legal(input bit we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    int sz;
    logic [63:0] m;
    logic [31:0] v;
    sz = ref_size(f3);
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[(int'(addr[5:0]) + i) % 64]) << (8 * i));
    m = (64'd1 << (8 * sz)) - 64'd1;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~m[31:0];
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
    int sz;
    sz = ref_size(f3);
    for (int i = 0; i < sz; i++) ref_mem[(int'(addr[5:0]) + i) % 64] = wd[8*i +: 8];
  endtask

  // Drive one request and observe it through to the response pulse and the cycle after.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3);
    int n;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    req_func3 = f3;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    r_lat = 0;
    r_bus_cycles = 0;
    r_unstable = 0;
    while (!rsp_valid && r_lat < 200) begin
      if (bus_req) begin
        if (r_bus_cycles == 0) begin
          r_we = bus_we;
          r_addr = bus_addr;
          r_be = bus_be;
          r_wdata = bus_wdata;
        end else if (bus_we !== r_we || bus_addr !== r_addr || bus_be !== r_be ||
                     bus_wdata !== r_wdata) begin
          r_unstable = 1;
        end
        r_bus_cycles++;
      end
      @(posedge clk);
      #1;
      r_lat++;
    end
    chk("rsp_seen", rsp_valid, 1);
    r_overlap = bus_req;
    r_rdata = rsp_rdata;
    r_err = rsp_err;
    @(posedge clk);
    #1;
    r_after_valid = rsp_valid;
    r_after_ready = req_ready;
  endtask

  // One request checked end-to-end against the model; wait states from w.
  task automatic do_op(input string tag, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3, input int w);
    bit legal;
    bit aligned;
    int sz;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int exp_lat;
    int exp_cycles;
    int be_i;
    legal = ref_legal(we, f3);
    sz = ref_size(f3);
    aligned = (int'(addr[1:0]) % sz) == 0;
    exp_rdata = 32'h0;
    if (!legal) begin
      exp_err = 2'b11; exp_lat = 0; exp_cycles = 0;
    end else if (!aligned) begin
      exp_err = 2'b01; exp_lat = 0; exp_cycles = 0;
    end else if (hold_low) begin
      exp_err = 2'b10; exp_lat = TO; exp_cycles = TO;
    end else begin
      exp_err = 2'b00; exp_lat = 1 + w; exp_cycles = 1 + w;
      if (we) ref_store(addr, wd, f3);
      else exp_rdata = ref_load(addr, f3);
    end
    wait_cfg = w;
    run_req(we, addr, wd, f3);
    chk({tag, "_err"}, r_err, exp_err);
    chk({tag, "_rdata"}, r_rdata, exp_rdata);
    chk({tag, "_lat"}, r_lat, exp_lat);
    chk({tag, "_buscyc"}, r_bus_cycles, exp_cycles);
    chk({tag, "_overlap"}, r_overlap, 0);
    chk({tag, "_pulse"}, r_after_valid, 0);
    chk({tag, "_ready_after"}, r_after_ready, 1);
    if (exp_cycles > 0) begin
      be_i = we ? (((1 << sz) - 1) << int'(addr[1:0])) : 15;
      chk({tag, "_stable"}, r_unstable, 0);
      chk({tag, "_bus_we"}, r_we, we);
      chk({tag, "_bus_addr"}, r_addr, {addr[31:2], 2'b00});
      chk({tag, "_bus_be"}, r_be, be_i[3:0]);
    end
  endtask

  initial begin
    bit saw;
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    req_func3 = 3'b000;
    for (int i = 0; i < 64; i++) begin
      slv_mem[i] = 8'($urandom);
      ref_mem[i] = slv_mem[i];
    end

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);

    // Store a word, then read it back as bytes and halves.
    do_op("sw8", 1, 32'h8, 32'hDEADBEEF, 3'b010, 0);
    chk("sw8_be", r_be, 4'b1111);
    chk("sw8_addr", r_addr, 32'h8);
    chk("sw8_wdata", r_wdata, 32'hDEADBEEF);
    do_op("lb_b", 0, 32'hB, 32'h0, 3'b000, 0);
    chk("lb_b_val", r_rdata, 32'hFFFFFFDE);
    do_op("lbu_b", 0, 32'hB, 32'h0, 3'b100, 0);
    chk("lbu_b_val", r_rdata, 32'h000000DE);
    do_op("lh_a", 0, 32'hA, 32'h0, 3'b001, 0);
    chk("lh_a_val", r_rdata, 32'hFFFFDEAD);
    do_op("lhu_8", 0, 32'h8, 32'h0, 3'b101, 0);
    chk("lhu_8_val", r_rdata, 32'h0000BEEF);

    // Byte and half stores: lane enables and replication.
    do_op("sb5", 1, 32'h5, 32'h12345678, 3'b000, 0);
    chk("sb5_addr", r_addr, 32'h4);
    chk("sb5_be", r_be, 4'b0010);
    chk("sb5_wdata", r_wdata, 32'h78787878);
    do_op("sh6", 1, 32'h6, 32'h12345678, 3'b001, 0);
    chk("sh6_be", r_be, 4'b1100);
    chk("sh6_wdata", r_wdata, 32'h56785678);
    do_op("lw4", 0, 32'h4, 32'h0, 3'b010, 1);

    // Error paths, with a stray bus_ready that must be ignored.
    force_ready = 1;
    do_op("lw_mis", 0, 32'h6, 32'h0, 3'b010, 0);
    chk("lw_mis_code", r_err, 2'b01);
    do_op("ld_ill", 0, 32'h0, 32'h0, 3'b011, 0);
    chk("ld_ill_code", r_err, 2'b11);
    do_op("st_ill", 1, 32'h0, 32'h0, 3'b100, 0);
    do_op("lh_mis", 0, 32'h3, 32'h0, 3'b101, 0);
    force_ready = 0;

    // Wait states and timeout.
    do_op("lw_wait3", 0, 32'h8, 32'h0, 3'b010, 3);
    chk("lw_wait3_lat", r_lat, 4);
    chk("lw_wait3_val", r_rdata, 32'hDEADBEEF);
    hold_low = 1;
    do_op("lw_tmo", 0, 32'h8, 32'h0, 3'b010, 0);
    chk("lw_tmo_code", r_err, 2'b10);
    chk("lw_tmo_cycles", r_bus_cycles, 16);
    do_op("sw_tmo", 1, 32'hC, 32'hCAFEF00D, 3'b010, 0);

    // Asynchronous reset in the middle of a transfer.
    req_we = 1'b0;
    req_addr = 32'h8;
    req_func3 = 3'b010;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_busy", bus_req, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_bus_req", bus_req, 0);
    chk("arst_bus_be", bus_be, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    hold_low = 0;
    @(posedge clk);
    #1;
    chk("arst_ready", req_ready, 1);
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid || bus_req) saw = 1;
      @(posedge clk);
      #1;
    end
    chk("arst_no_rsp", saw, 0);

    // Back-to-back: req_valid held across two requests.
    wait_cfg = 0;
    req_we = 1'b1;
    req_addr = 32'h10;
    req_wdata = 32'h11223344;
    req_func3 = 3'b010;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    ref_store(32'h10, 32'h11223344, 3'b010);
    req_we = 1'b0;
    req_wdata = 32'h0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_rsp1", rsp_valid, 1);
    chk("b2b_rsp1_err", rsp_err, 0);
    chk("b2b_no_overlap", bus_req, 0);
    chk("b2b_busy_in_resp", req_ready, 0);
    @(posedge clk);
    #1;
    chk("b2b_ready_after", req_ready, 1);
    chk("b2b_pulse", rsp_valid, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("b2b_second_req", bus_req, 1);
    chk("b2b_second_we", bus_we, 0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_rsp2", rsp_valid, 1);
    chk("b2b_rsp2_val", rsp_rdata, ref_load(32'h10, 3'b010));
    chk("b2b_rsp2_const", rsp_rdata, 32'h11223344);
    @(posedge clk);
    #1;

    // Randomized loads and stores against the memory model.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [2:0]  f;
      bit          w_e;
      a = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
      w_e = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f = w_e ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      if (!w_e && f == 3'd3) f = 3'd4;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      do_op("rnd", w_e, a, $urandom, f, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
